// File: rtl/print_fmt_tx.sv
// rtl/print_fmt_tx.sv - UART print formatter: command FIFO plus character expansion engine
//
// print_fmt_tx_cmd_fifo : small command queue, push/pop with occupancy count
//   clk, rstn           clock, asynchronous active-low reset
//   push, push_data     write one entry (caller guarantees not full)
//   pop, pop_data       read/remove head entry (caller guarantees not empty); head visible combinationally
//   count               current number of entries
//
// print_fmt_tx : print command in, ASCII character stream out
//   clk, rstn                     clock, asynchronous active-low reset
//   req_tx, dout_tx, mode_tx      command request (level), data word, mode
//   ack_tx                        one-cycle accept pulse
//   rdy_tx, d_tx, vld_tx          byte stream to UART (transfer on vld_tx & rdy_tx)
//   busy                          FIFO non-empty or engine active (registered)

module print_fmt_tx_cmd_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: entries are only read when count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

module print_fmt_tx #(
  parameter int         DW         = 32,
  parameter int         GRP        = 4,
  parameter logic [7:0] SEP        = 8'h5f,
  parameter int         FIFO_DEPTH = 4,
  parameter int         UPPER      = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_tx,
  input  logic [DW-1:0] dout_tx,
  input  logic [1:0]    mode_tx,
  output logic          ack_tx,
  input  logic          rdy_tx,
  output logic [7:0]    d_tx,
  output logic          vld_tx,
  output logic          busy
);

  localparam int NIB   = DW / 4;
  localparam int IW    = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  // Divisor that is never zero; the GRP==0 case is excluded before it is used.
  localparam int GRP_M = (GRP == 0) ? 1 : GRP;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEX,
    S_SEP,
    S_RAW,
    S_CR,
    S_LF
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      mode_q, mode_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx_m1;
  logic [7:0]      d_d;
  logic            vld_d;

  logic            accept;
  logic            pop;
  logic [DW+1:0]   fifo_head;
  logic [CW-1:0]   fifo_count;

  // ack_tx blocks a second accept of the same still-held request.
  assign accept = req_tx && !ack_tx && (fifo_count < CW'(FIFO_DEPTH));
  assign idx_m1 = idx_q - 1'b1;

  print_fmt_tx_cmd_fifo #(
    .W     (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data ({mode_tx, dout_tx}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] base;
    base = (UPPER != 0) ? 8'h41 : 8'h61;
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return base + {4'h0, n} - 8'd10;
  endfunction

  // Next-state logic also computes the next registered character, so d_tx/vld_tx
  // always describe the character owned by the state being entered.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    d_d     = d_tx;
    vld_d   = vld_tx;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop    = 1'b1;
          data_d = fifo_head[DW-1:0];
          mode_d = fifo_head[DW+1:DW];
          idx_d  = IW'(NIB - 1);
          vld_d  = 1'b1;
          case (fifo_head[DW+1:DW])
            2'b00: begin
              state_d = S_RAW;
              d_d     = fifo_head[7:0];
            end
            2'b10: begin
              state_d = S_CR;
              d_d     = 8'h0d;
            end
            default: begin
              state_d = S_HEX;
              d_d     = hex_char(fifo_head[DW-1 -: 4]);
            end
          endcase
        end
      end

      S_RAW: begin
        if (rdy_tx) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end
      end

      S_HEX: begin
        if (rdy_tx) begin
          idx_d = idx_m1;
          if (idx_q == '0) begin
            if (mode_q == 2'b11) begin
              state_d = S_CR;
              d_d     = 8'h0d;
            end else begin
              state_d = S_IDLE;
              vld_d   = 1'b0;
            end
          end else if ((GRP != 0) && ((int'(idx_q) % GRP_M) == 0)) begin
            // Groups are counted from the least significant nibble.
            state_d = S_SEP;
            d_d     = SEP;
          end else begin
            state_d = S_HEX;
            d_d     = hex_char(data_q[{idx_m1, 2'b00} +: 4]);
          end
        end
      end

      S_SEP: begin
        if (rdy_tx) begin
          state_d = S_HEX;
          d_d     = hex_char(data_q[{idx_q, 2'b00} +: 4]);
        end
      end

      S_CR: begin
        if (rdy_tx) begin
          state_d = S_LF;
          d_d     = 8'h0a;
        end
      end

      S_LF: begin
        if (rdy_tx) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      d_tx    <= '0;
      vld_tx  <= 1'b0;
      ack_tx  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      d_tx    <= d_d;
      vld_tx  <= vld_d;
      ack_tx  <= accept;
      busy    <= (fifo_count != '0) || (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_print_fmt_tx.sv
// tb/tb_print_fmt_tx.sv - randomized self-checking bench for print_fmt_tx

module tb_print_fmt_tx;

  localparam int DW  = 32;
  localparam int GRP = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_tx;
  logic [DW-1:0] dout_tx;
  logic [1:0]    mode_tx;
  logic          ack_tx;
  logic          rdy_tx;
  logic [7:0]    d_tx;
  logic          vld_tx;
  logic          busy;

  logic          req_b;
  logic [15:0]   dout_b;
  logic [1:0]    mode_b;
  logic          ack_b;
  logic          rdy_b;
  logic [7:0]    d_b;
  logic          vld_b;
  logic          busy_b;

  always #5 clk = ~clk;

  print_fmt_tx #(.DW(32), .GRP(4), .SEP(8'h5f), .FIFO_DEPTH(4), .UPPER(0)) dut (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .dout_tx(dout_tx), .mode_tx(mode_tx),
    .ack_tx(ack_tx), .rdy_tx(rdy_tx), .d_tx(d_tx), .vld_tx(vld_tx), .busy(busy)
  );

  print_fmt_tx #(.DW(16), .GRP(0), .SEP(8'h5f), .FIFO_DEPTH(2), .UPPER(1)) dut_b (
    .clk(clk), .rstn(rstn), .req_tx(req_b), .dout_tx(dout_b), .mode_tx(mode_b),
    .ack_tx(ack_b), .rdy_tx(rdy_b), .d_tx(d_b), .vld_tx(vld_b), .busy(busy_b)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  byte unsigned got_b[$];
  byte unsigned exp_b[$];
  bit           rnd_rdy = 1'b0;
  bit           hold_chk = 1'b0;
  byte unsigned hold_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full hex text of the word, letters case-adjusted, separators
  // inserted between groups of grp digits counted from the right.
  function automatic string hex_text(input int dw, input int grp, input bit upper,
                                     input logic [63:0] data);
    string full, digits, s;
    int n;
    n = dw / 4;
    full = $sformatf("%016h", data);
    digits = full.substr(16 - n, 15);
    if (upper) digits = digits.toupper();
    s = "";
    for (int i = 0; i < n; i++) begin
      s = {s, digits.substr(i, i)};
      if (grp != 0 && i != n - 1 && ((n - 1 - i) % grp) == 0) s = {s, "_"};
    end
    return s;
  endfunction

  task automatic exp_push(input logic [1:0] m, input logic [DW-1:0] d);
    string h;
    if (m == 2'b00) begin
      exp_q.push_back(d[7:0]);
    end else begin
      if (m == 2'b01 || m == 2'b11) begin
        h = hex_text(DW, GRP, 1'b0, 64'(d));
        for (int i = 0; i < h.len(); i++) exp_q.push_back(h[i]);
      end
      exp_q.push_back(8'h0d);
      exp_q.push_back(8'h0a);
      if (m == 2'b01) begin
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
      end
    end
  endtask

  task automatic exp_push_b(input logic [1:0] m, input logic [15:0] d);
    string h;
    if (m == 2'b00) begin
      exp_b.push_back(d[7:0]);
    end else begin
      if (m[0]) begin
        h = hex_text(16, 0, 1'b1, 64'(d));
        for (int i = 0; i < h.len(); i++) exp_b.push_back(h[i]);
      end
      if (m[1]) begin
        exp_b.push_back(8'h0d);
        exp_b.push_back(8'h0a);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (hold_chk) begin
        chk("hold_vld", vld_tx, 1'b1);
        chk("hold_d", d_tx, hold_d);
      end
      hold_chk = vld_tx && !rdy_tx;
      hold_d   = d_tx;
      if (vld_tx && rdy_tx) got_q.push_back(d_tx);
      if (vld_b && rdy_b) got_b.push_back(d_b);
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic send(input logic [1:0] m, input logic [DW-1:0] d);
    int t;
    req_tx  = 1'b1;
    mode_tx = m;
    dout_tx = d;
    t = 0;
    do begin
      @(posedge clk); #1;
      if (rnd_rdy) rdy_tx = ($urandom_range(0, 3) != 0);
      t++;
    end while (!ack_tx && t < 2000);
    if (!ack_tx) chk("ack_timeout", 1'b0, 1'b1);
    else exp_push(m, d);
    req_tx = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((busy || vld_tx || got_q.size() < exp_q.size()) && t < 5000) begin
      @(posedge clk); #1;
      rdy_tx = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    bit saw;
    logic [1:0] m;
    logic [DW-1:0] d;

    rstn = 1'b0; req_tx = 1'b0; dout_tx = '0; mode_tx = 2'b00; rdy_tx = 1'b1;
    req_b = 1'b0; dout_b = '0; mode_b = 2'b00; rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_tx, 1'b0);
    chk("rst_vld", vld_tx, 1'b0);
    chk("rst_d", d_tx, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(2'b01, 32'h1234abcd);
    chk("lat_ack", ack_tx, 1'b1);
    chk("lat_vld0", vld_tx, 1'b0);
    @(posedge clk); #1;
    chk("lat_vld1", vld_tx, 1'b1);
    chk("lat_first", d_tx, 8'h31);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("b2b_vld", vld_tx, 1'b1);
    end
    @(posedge clk); #1;
    chk("b2b_gap", vld_tx, 1'b0);
    drain("hex");

    send(2'b01, 32'h1234abcd);
    t = 0;
    while (got_q.size() < 4 && t < 100) begin @(posedge clk); #1; t++; end
    rdy_tx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", vld_tx, 1'b1);
      chk("bp_d", d_tx, 8'h5f);
    end
    rdy_tx = 1'b1;
    drain("bp");

    send(2'b00, 32'h00000041);
    send(2'b10, 32'h0);
    send(2'b11, 32'h0);
    drain("modes");

    rdy_tx = 1'b0;
    send(2'b11, 32'h0);
    for (int i = 0; i < 4; i++) send(2'($urandom_range(0, 3)), $urandom);
    m = 2'($urandom_range(0, 3));
    d = $urandom;
    req_tx = 1'b1; mode_tx = m; dout_tx = d;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_tx) saw = 1'b1;
    end
    chk("full_noack", saw, 1'b0);
    chk("full_busy", busy, 1'b1);
    rdy_tx = 1'b1;
    t = 0;
    while (!ack_tx && t < 200) begin @(posedge clk); #1; t++; end
    chk("full_ack6", ack_tx, 1'b1);
    chk("full_first_done", got_q.size() >= 11, 1'b1);
    if (ack_tx) exp_push(m, d);
    req_tx = 1'b0;
    drain("full");

    rdy_tx = 1'b0;
    send(2'b01, 32'hdeadbeef);
    send(2'b11, 32'h0badf00d);
    chk("pre_rst_vld", vld_tx, 1'b1);
    chk("pre_rst_ack", ack_tx, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_ack", ack_tx, 1'b0);
    chk("arst_vld", vld_tx, 1'b0);
    chk("arst_d", d_tx, 8'h00);
    chk("arst_busy", busy, 1'b0);
    got_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rdy_tx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_vld", vld_tx, 1'b0);
    chk("post_rst_nobytes", got_q.size(), 0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send(2'($urandom_range(0, 3)), $urandom);
    drain("rand");
    rnd_rdy = 1'b0;
    rdy_tx = 1'b1;

    for (int k = 0; k < 4; k++) begin
      mode_b = (k == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      dout_b = (k == 0) ? 16'hbeef : 16'($urandom);
      req_b = 1'b1;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!ack_b && t < 200);
      chk("var_ack", ack_b, 1'b1);
      exp_push_b(mode_b, dout_b);
      req_b = 1'b0;
    end
    t = 0;
    while ((busy_b || vld_b || got_b.size() < exp_b.size()) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk("var_first4_0", got_b.size() > 0 ? got_b[0] : 8'h00, 8'h42);
    chk("var_first4_3", got_b.size() > 3 ? got_b[3] : 8'h00, 8'h46);
    chk("var_len", got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk("var_byte", got_b[i], exp_b[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/print_fmt_tx.md
Name: print_fmt_tx

Overview:
Parametrised UART print formatter between the CPU print port and the UART transmitter. It accepts print commands over a req/ack handshake into a small command FIFO, so the CPU does not stall for a whole line. Each command is expanded into a character stream: a raw byte, grouped hex with separators, CR LF, or hex followed by CR LF. Characters are delivered through a vld/rdy byte interface.

Parameters:
DW, 32, data word width in bits; multiple of 4, range 8..64
GRP, 4, hex nibbles per separator group; 0 = no separators
SEP, 8'h5f, separator character ('_')
FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2
UPPER, 0, 1 = hex letters 'A'-'F' (0x41+); 0 = 'a'-'f' (0x61+)

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  asynchronous active-low reset
req_tx  in  1  command request, level; held by requester until ack_tx
dout_tx  in  DW  command data, sampled with req_tx
mode_tx  in  2  00 raw byte dout_tx[7:0]; 01 hex word; 10 CR LF only; 11 hex word then CR LF
ack_tx  out  1  one-cycle pulse: command accepted
rdy_tx  in  1  UART can take a byte this cycle
d_tx  out  8  character to UART
vld_tx  out  1  d_tx valid
busy  out  1  FIFO non-empty, or engine not IDLE

Behaviour:
- Reset (asynchronous, active-low rstn): ack_tx=0, vld_tx=0, d_tx=0, busy=0. FIFO is emptied and engine goes to IDLE. A partially sent command is discarded.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Accept rule: accept at an edge when req_tx=1, ack_tx=0 and FIFO count < FIFO_DEPTH. On accept, {mode_tx, dout_tx} is written and ack_tx=1 for exactly the next cycle.
  - The requester drops req_tx after seeing ack_tx.
  - While ack_tx=1, req_tx is ignored, so there is no double accept.
- Full FIFO: a push is refused even if a pop happens in the same cycle. req_tx stays pending with no ack.
- UART handshake: a byte transfers on an edge with vld_tx=1 and rdy_tx=1. While vld_tx=1 and rdy_tx=0, d_tx and vld_tx hold stable. All outputs are registered.
- Engine states: IDLE, HEX, SEP, RAW, CR, LF.
  - IDLE: if the FIFO is non-empty, pop. Load the data shift register and set nibble index = DW/4-1. Present the first character with vld_tx=1 on the next cycle.
    - mode 00 -> RAW
    - mode 01/11 -> HEX
    - mode 10 -> CR
  - RAW: d_tx = dout[7:0]. On transfer -> IDLE.
  - HEX: d_tx = ASCII of nibble[idx].
    - Digits 0-9 map to 0x30+n. Values 10-15 map to 0x61+(n-10), or 0x41+(n-10) if UPPER.
    - On transfer:
      - if idx=0 -> CR when mode=11, else IDLE
      - else if GRP≠0 and idx%GRP==0 -> SEP
      - else HEX; idx decrements on every HEX transfer
  - SEP: d_tx = SEP. On transfer -> HEX.
  - CR: d_tx = 8'h0d. On transfer -> LF.
  - LF: d_tx = 8'h0a. On transfer -> IDLE.
  - When no character is pending, vld_tx=0 and d_tx holds its last value.
- Throughput: back-to-back characters within a command, one per cycle while rdy_tx=1. After the last transfer there is one idle cycle (vld_tx=0) before the next command's first character.
- Latency: with engine idle and FIFO empty, accept at edge E gives ack_tx high in cycle E..E+1 and pop at edge E+1. The first vld_tx=1 follows edge E+1.
- Character count for hex: DW/4 + (GRP? (DW/4-1)/GRP : 0), plus 2 for mode 11.
- busy is registered and updates one cycle after state/FIFO changes. It is 0 only when the FIFO is empty and the engine is in IDLE.

Test Plan:
- Reset: assert rstn=0 mid-run -> ack_tx=0, vld_tx=0, d_tx=0x00, busy=0 asynchronously, with no clock edge needed.
- Hex word: DW=32, GRP=4, mode 01, dout 0x1234ABCD, rdy_tx=1 -> 9 consecutive bytes 31 32 33 34 5f 61 62 63 64. First vld_tx 2 edges after accept.
- Backpressure: same command with rdy_tx=0 for 3 cycles after the 4th byte -> d_tx=0x5f held stable with vld_tx=1, sequence unchanged, no drop or duplicate.
- Modes: mode 00 dout 0x41 -> single 0x41. Mode 10 -> 0d 0a. Mode 11 dout 0 -> 30 30 30 30 5f 30 30 30 30 0d 0a.
- FIFO full: rdy_tx=0, FIFO_DEPTH=4, six back-to-back requests -> five acked (one in engine plus four queued). Sixth req_tx waits with ack_tx=0 until the first command finishes and a pop frees a slot. Output order is preserved.
- Variant: DW=16, GRP=0, UPPER=1, mode 01 dout 0xBEEF -> 42 45 45 46, no separators.
